// File: rtl/sonar_varredura.sv
// sonar_varredura: parametrised sawtooth/ping-pong scan sequencer with per-position distance store and hysteretic proximity alerts
module sonar_varredura #(
  parameter int POSICOES       = 8,
  parameter int NB_POS         = 3,
  parameter int DIST_W         = 12,
  parameter int ESPERA_CICLOS  = 100000000,
  parameter int TIMEOUT_CICLOS = 150000000,
  parameter int HIST           = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic                parar,
  input  logic                modo,
  input  logic [DIST_W-1:0]   limiar,
  output logic                medir,
  input  logic                medida_pronto,
  input  logic [DIST_W-1:0]   medida,
  output logic                transmitir,
  input  logic                envio_pronto,
  output logic [NB_POS-1:0]   posicao,
  output logic [NB_POS-1:0]   dado_posicao,
  output logic [DIST_W-1:0]   dado_medida,
  output logic                dado_timeout,
  output logic [POSICOES-1:0] alerta_vec,
  output logic                alerta,
  output logic                fim_varredura,
  input  logic [NB_POS-1:0]   leitura_end,
  output logic [DIST_W-1:0]   leitura_dado,
  output logic [3:0]          db_estado
);
  typedef enum logic [3:0] {
    INICIAL = 4'd0, ESPERA = 4'd1, MEDE = 4'd2, AGUARDA = 4'd3, ARMAZENA = 4'd4,
    TRANSMITE = 4'd5, AGUARDA_ENVIO = 4'd6, AVANCA = 4'd7, PAUSA = 4'd8
  } estado_t;
  localparam logic [NB_POS-1:0] ULT = NB_POS'(POSICOES - 1);
  estado_t estado;
  logic [31:0] cnt_espera, cnt_timeout;
  logic [DIST_W-1:0] capt;
  logic capt_to, desce, sobe, prox_desce, abaixo, acima;
  logic [NB_POS-1:0] prox;
  // Sized to the full address space so out-of-range reads hit rows that stay all ones
  logic [DIST_W-1:0] mem [2**NB_POS];
  always_comb begin
    sobe       = !modo || (desce ? posicao == '0 : posicao != ULT);
    prox       = sobe ? (posicao == ULT ? '0 : posicao + 1'b1) : posicao - 1'b1;
    prox_desce = modo && (sobe ? prox == ULT : prox != '0);
    abaixo     = capt < limiar;
    acima      = {1'b0, capt} >= {1'b0, limiar} + (DIST_W + 1)'(HIST);
  end
  assign alerta    = |alerta_vec;
  assign db_estado = estado;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= INICIAL;
      posicao       <= '0;
      desce         <= 1'b0;
      cnt_espera    <= '0;
      cnt_timeout   <= '0;
      capt          <= '0;
      capt_to       <= 1'b0;
      dado_posicao  <= '0;
      dado_medida   <= '0;
      dado_timeout  <= 1'b0;
      alerta_vec    <= '0;
      medir         <= 1'b0;
      transmitir    <= 1'b0;
      fim_varredura <= 1'b0;
      mem           <= '{default: '1};
      leitura_dado  <= '1;
    end else begin
      medir         <= 1'b0;
      transmitir    <= 1'b0;
      fim_varredura <= 1'b0;
      leitura_dado  <= mem[leitura_end];
      case (estado)
        INICIAL: begin
          posicao    <= '0;
          desce      <= 1'b0;
          cnt_espera <= '0;
          if (ligar) estado <= ESPERA;
        end
        ESPERA: begin
          cnt_espera <= cnt_espera + 1'b1;
          if (!ligar) estado <= INICIAL;
          else if (parar) estado <= PAUSA;
          else if (cnt_espera == 32'(ESPERA_CICLOS - 1)) begin
            estado <= MEDE;
            medir  <= 1'b1;
          end
        end
        MEDE: begin
          cnt_timeout <= '0;
          estado      <= AGUARDA;
        end
        AGUARDA: begin
          cnt_timeout <= cnt_timeout + 1'b1;
          if (medida_pronto) begin
            capt    <= medida;
            capt_to <= 1'b0;
            estado  <= ARMAZENA;
          end else if (cnt_timeout == 32'(TIMEOUT_CICLOS - 1)) begin
            capt    <= '1;
            capt_to <= 1'b1;
            estado  <= ARMAZENA;
          end
        end
        ARMAZENA: begin
          mem[posicao]        <= capt;
          dado_posicao        <= posicao;
          dado_medida         <= capt;
          dado_timeout        <= capt_to;
          alerta_vec[posicao] <= (!capt_to && abaixo) ? 1'b1 : (capt_to || acima) ? 1'b0 : alerta_vec[posicao];
          transmitir          <= 1'b1;
          estado              <= TRANSMITE;
        end
        TRANSMITE: estado <= AGUARDA_ENVIO;
        AGUARDA_ENVIO: if (envio_pronto) estado <= AVANCA;
        AVANCA: begin
          posicao       <= prox;
          desce         <= prox_desce;
          fim_varredura <= prox == '0;
          cnt_espera    <= '0;
          estado        <= ESPERA;
        end
        PAUSA: begin
          if (!ligar) estado <= INICIAL;
          else if (!parar) begin
            cnt_espera <= '0;
            estado     <= ESPERA;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end
endmodule

// File: tb/tb_sonar_varredura.sv
// tb_sonar_varredura: scoreboard bench for the scan sequencer with a 4-position, short-interval configuration
module tb_sonar_varredura;
  localparam int P = 4, NB = 3, W = 12, ESP = 10, TO = 50, HIST = 2;
  logic clock = 1'b0, reset = 1'b0, ligar = 1'b0, parar = 1'b0, modo = 1'b0;
  logic medida_pronto = 1'b0, envio_pronto = 1'b0;
  logic [W-1:0] limiar = 12'd30, medida = '0;
  logic [NB-1:0] leitura_end = '0;
  logic medir, transmitir, dado_timeout, alerta, fim_varredura;
  logic [NB-1:0] posicao, dado_posicao;
  logic [W-1:0] dado_medida, leitura_dado;
  logic [P-1:0] alerta_vec;
  logic [3:0] db_estado;

  sonar_varredura #(.POSICOES(P), .NB_POS(NB), .DIST_W(W), .ESPERA_CICLOS(ESP),
                    .TIMEOUT_CICLOS(TO), .HIST(HIST)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .parar(parar), .modo(modo), .limiar(limiar),
    .medir(medir), .medida_pronto(medida_pronto), .medida(medida), .transmitir(transmitir),
    .envio_pronto(envio_pronto), .posicao(posicao), .dado_posicao(dado_posicao),
    .dado_medida(dado_medida), .dado_timeout(dado_timeout), .alerta_vec(alerta_vec),
    .alerta(alerta), .fim_varredura(fim_varredura), .leitura_end(leitura_end),
    .leitura_dado(leitura_dado), .db_estado(db_estado));

  always #5 clock = ~clock;

  int ciclo = 0;
  always @(posedge clock) ciclo++;
  int fim_cnt = 0;
  always @(negedge clock) if (reset && fim_varredura) fim_cnt++;

  int erros = 0, total = 0;
  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  typedef struct {int pos; bit md; int valor; int atraso; bit resp;} passo_t;
  typedef struct {logic [NB-1:0] pos; logic [W-1:0] med; logic to;} amostra_t;
  amostra_t fila[$];
  logic [W-1:0] mem_esp [P];
  logic [P-1:0] alerta_esp = '0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic verifica_reset(input string tag);
    confere({tag, "_estado"}, db_estado, 0);
    confere({tag, "_posicao"}, posicao, 0);
    confere({tag, "_dado_posicao"}, dado_posicao, 0);
    confere({tag, "_dado_medida"}, dado_medida, 0);
    confere({tag, "_dado_timeout"}, dado_timeout, 0);
    confere({tag, "_alerta_vec"}, alerta_vec, 0);
    confere({tag, "_alerta"}, alerta, 0);
    confere({tag, "_medir"}, medir, 0);
    confere({tag, "_transmitir"}, transmitir, 0);
    confere({tag, "_fim"}, fim_varredura, 0);
    confere({tag, "_leitura"}, leitura_dado, 12'hFFF);
  endtask

  task automatic le_tudo(input string tag);
    for (int a = 0; a < 8; a++) begin
      leitura_end = NB'(a);
      tick();
      confere(tag, leitura_dado, a < P ? 32'(mem_esp[a]) : 32'hFFF);
    end
  endtask

  // acao: 0 none, 1 raise parar during AGUARDA, 2 drop ligar during AGUARDA_ENVIO
  task automatic executa(input passo_t p, input int acao, output int t_medir);
    int n;
    amostra_t e;
    n = 0;
    t_medir = ciclo;
    while (!medir && n < 200) begin tick(); n++; end
    confere("medir", medir, 1);
    if (!medir) return;
    t_medir = ciclo;
    confere("posicao", posicao, p.pos);
    fila.push_back('{pos: NB'(p.pos), med: p.resp ? W'(p.valor) : 12'hFFF, to: !p.resp});
    leitura_end = NB'(p.pos);
    if (acao == 1) parar = 1'b1;
    n = 0;
    while (!transmitir && n < 200) begin
      tick();
      n++;
      medida = W'(p.valor);
      medida_pronto = p.resp && n == p.atraso;
    end
    medida_pronto = 1'b0;
    confere("latencia", n, (p.resp ? p.atraso : TO) + 2);
    e = fila.pop_front();
    confere("dado_posicao", dado_posicao, e.pos);
    confere("dado_medida", dado_medida, e.med);
    confere("dado_timeout", dado_timeout, e.to);
    confere("leitura_antiga", leitura_dado, mem_esp[e.pos]);
    mem_esp[e.pos] = e.med;
    if (!e.to && e.med < limiar) alerta_esp[e.pos] = 1'b1;
    else if (e.to || e.med >= limiar + HIST) alerta_esp[e.pos] = 1'b0;
    confere("alerta_vec", alerta_vec, alerta_esp);
    confere("alerta", alerta, |alerta_esp);
    if (acao == 2) ligar = 1'b0;
    repeat (3) tick();
    confere("aguarda_envio", db_estado, 6);
    envio_pronto = 1'b1;
    tick();
    envio_pronto = 1'b0;
    confere("avanca", db_estado, 7);
    confere("leitura_nova", leitura_dado, mem_esp[e.pos]);
    tick();
  endtask

  passo_t tab[17] = '{
    '{0, 0, 100, 5, 1}, '{1, 0, 101, 5, 1}, '{2, 0, 10, 5, 1}, '{3, 0, 103, 5, 1},
    '{0, 0, 104, 5, 1}, '{1, 1, 29, 5, 1}, '{2, 1, 0, 5, 0}, '{3, 1, 107, 50, 1},
    '{2, 1, 108, 5, 1}, '{1, 1, 31, 5, 1}, '{0, 1, 110, 5, 1}, '{1, 1, 32, 5, 1},
    '{2, 1, 112, 5, 1}, '{3, 1, 113, 5, 1}, '{2, 0, 114, 5, 1}, '{3, 0, 115, 5, 1},
    '{0, 0, 116, 5, 1}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: obtido=stall esperado=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tm, tprev, n;
    mem_esp = '{default: 12'hFFF};
    repeat (3) tick();
    verifica_reset("reset_inicial");
    reset = 1'b1;
    le_tudo("leitura_inicial");
    ligar = 1'b1;
    tprev = 0;
    for (int i = 0; i < 17; i++) begin
      modo = tab[i].md;
      executa(tab[i], 0, tm);
      if (i > 0) confere("periodo", tm - tprev, 17 + (tab[i-1].resp ? tab[i-1].atraso : TO));
      tprev = tm;
    end
    confere("fim_cnt", fim_cnt, 3);
    executa('{1, 0, 5, 5, 1}, 1, tm);
    tick();
    confere("pausa", db_estado, 8);
    n = 0;
    repeat (30) begin tick(); if (medir) n++; end
    confere("medir_em_pausa", n, 0);
    confere("pausa_posicao", posicao, 2);
    parar = 1'b0;
    n = 0;
    while (!medir && n < 50) begin tick(); n++; end
    confere("retomada", n, 11);
    executa('{2, 0, 121, 5, 1}, 2, tm);
    confere("espera_desligado", db_estado, 1);
    tick();
    confere("inicial", db_estado, 0);
    tick();
    confere("inicial_posicao", posicao, 0);
    confere("alerta_mantido", alerta_vec, alerta_esp);
    le_tudo("leitura_final");
    ligar = 1'b1;
    n = 0;
    while (!medir && n < 50) begin tick(); n++; end
    confere("medir_pre_reset", medir, 1);
    repeat (2) tick();
    confere("aguarda_pre_reset", db_estado, 3);
    #2 reset = 1'b0;
    #1 verifica_reset("reset_aguarda");
    ligar = 1'b0;
    tick();
    reset = 1'b1;
    mem_esp = '{default: 12'hFFF};
    le_tudo("leitura_pos_reset");
    $display("Result: errors=%0d of %0d checks", erros, total);
    $finish;
  end
endmodule
